// File: rtl/key_event_enc_pkg.sv
// key_pkg: shared types and helpers for the keypad event encoder.
//   KEY_MAX_KEYS / KEY_CODE_MAX_W : upper bound on supported keypad width
//   key_ev_t                      : event queue entry (code, plus rel flag
//                                   when KEY_RELEASE_EV_EN is defined)
//   prio_enc()                    : lowest-index set bit -> code
//   popcount()                    : number of set bits
// Helpers take a zero-extended vector of KEY_MAX_KEYS bits so one function
// serves every N_KEYS; callers cast the result down to CODE_W.
package key_pkg;

    localparam int KEY_MAX_KEYS   = 256;
    localparam int KEY_CODE_MAX_W = 8;

    typedef struct packed {
`ifdef KEY_RELEASE_EV_EN
        logic                      rel;
`endif
        logic [KEY_CODE_MAX_W-1:0] code;
    } key_ev_t;

    function automatic logic [KEY_CODE_MAX_W-1:0] prio_enc(input logic [KEY_MAX_KEYS-1:0] v);
        prio_enc = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = KEY_MAX_KEYS - 1; i >= 0; i--) begin
            if (v[i]) prio_enc = KEY_CODE_MAX_W'(i);
        end
    endfunction

    function automatic logic [KEY_CODE_MAX_W:0] popcount(input logic [KEY_MAX_KEYS-1:0] v);
        popcount = '0;
        for (int i = 0; i < KEY_MAX_KEYS; i++) begin
            popcount = popcount + (KEY_CODE_MAX_W + 1)'(v[i]);
        end
    endfunction

endpackage

// File: rtl/key_event_enc_if.sv
// key_event_enc_if: ready/valid key event stream.
//   ev_valid : queue non-empty               (master -> slave)
//   ev_code  : code of the head entry        (master -> slave)
//   ev_rel   : head entry is a release       (master -> slave, only with
//              KEY_RELEASE_EV_EN defined)
//   ev_ready : consumer pops head when valid (slave -> master)
interface key_event_enc_if #(
    parameter int CODE_W = 4
);
    logic              ev_valid;
    logic [CODE_W-1:0] ev_code;
    logic              ev_ready;
`ifdef KEY_RELEASE_EV_EN
    logic              ev_rel;
`endif

    modport master (
        output ev_valid,
        output ev_code,
`ifdef KEY_RELEASE_EV_EN
        output ev_rel,
`endif
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
`ifdef KEY_RELEASE_EV_EN
        input  ev_rel,
`endif
        output ev_ready
    );
endinterface

// File: rtl/key_event_enc_debounce.sv
// key_debounce: two-flop synchroniser plus whole-vector debouncer.
//   clk, nrst : clock, synchronous active-low reset
//   psw       : raw asynchronous switches
//   deb       : debounced vector (registered)
//   deb_nxt   : value deb takes at the next edge, so the parent can detect
//               transitions and register derived flags on the same edge
// One shared counter: any change anywhere in the vector restarts it.
module key_debounce #(
    parameter int N_KEYS       = 16,
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_KEYS-1:0] psw,
    output logic [N_KEYS-1:0] deb,
    output logic [N_KEYS-1:0] deb_nxt
);
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [N_KEYS-1:0] s1, s2, cand;
    logic [CNT_W-1:0]  cnt;

    // Once the counter saturates, deb is reloaded from cand every cycle;
    // that is a no-op while the vector stays stable.
    always_comb begin
        deb_nxt = deb;
        if (s2 == cand && cnt == LAST) deb_nxt = cand;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1   <= '0;
            s2   <= '0;
            cand <= '0;
            cnt  <= '0;
            deb  <= '0;
        end else begin
            s1  <= psw;
            s2  <= s1;
            deb <= deb_nxt;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/key_event_enc.sv
// key_event_enc: debounced keypad priority encoder with a press-event queue.
//   clk, nrst : clock, synchronous active-low reset
//   psw       : raw key switches, 1 = pressed
//   out       : code of the last debounced press (held)
//   pushed    : debounced vector non-zero
//   multi     : more than one debounced key down
//   overflow  : sticky, an event was dropped on a full queue
//   clr_ovf   : clears overflow (a same-cycle drop wins)
//   ev        : event stream (ev_valid/ev_code/ev_ready[/ev_rel])
// Optional: define KEY_RELEASE_EV_EN to also queue release events, flagged
// on ev_rel. N_KEYS is limited to key_pkg::KEY_MAX_KEYS.
module key_event_enc
    import key_pkg::*;
#(
    parameter int N_KEYS       = 16,
    parameter int CODE_W       = $clog2(N_KEYS),
    parameter int DEBOUNCE_CYC = 1000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [N_KEYS-1:0] psw,
    output logic [CODE_W-1:0] out,
    output logic              pushed,
    output logic              multi,
    output logic              overflow,
    input  logic              clr_ovf,
    key_event_enc_if.master   ev
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [N_KEYS-1:0] deb, deb_nxt;

    key_debounce #(
        .N_KEYS      (N_KEYS),
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
        .clk    (clk),
        .nrst   (nrst),
        .psw    (psw),
        .deb    (deb),
        .deb_nxt(deb_nxt)
    );

    logic    press;
    logic    ev_push;
    key_ev_t ev_wr;

    assign press = ~|deb & |deb_nxt;

    always_comb begin
        ev_push = 1'b0;
        ev_wr   = '0;
        if (press) begin
            ev_push    = 1'b1;
            ev_wr.code = prio_enc(KEY_MAX_KEYS'(deb_nxt));
        end
`ifdef KEY_RELEASE_EV_EN
        else if (|deb && ~|deb_nxt) begin
            // Release reports the key(s) that were down before the edge.
            ev_push    = 1'b1;
            ev_wr.code = prio_enc(KEY_MAX_KEYS'(deb));
            ev_wr.rel  = 1'b1;
        end
`endif
    end

    // Event queue: registered storage, head read straight from memory.
    key_ev_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, do_rd, do_wr, drop;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign do_rd = (count != '0) & ev.ev_ready;
    // A pop on the same edge frees the slot, so a full queue still accepts.
    assign do_wr = ev_push & (~full | do_rd);
    assign drop  = ev_push & full & ~do_rd;

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= ev_wr;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out      <= '0;
            pushed   <= 1'b0;
            multi    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count  <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
            pushed <= |deb_nxt;
            multi  <= popcount(KEY_MAX_KEYS'(deb_nxt)) > (KEY_CODE_MAX_W + 1)'(1);
            if (press) out <= CODE_W'(prio_enc(KEY_MAX_KEYS'(deb_nxt)));
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    assign ev.ev_valid = (count != '0);
    assign ev.ev_code  = CODE_W'(mem[rd_ptr].code);
`ifdef KEY_RELEASE_EV_EN
    assign ev.ev_rel   = mem[rd_ptr].rel;
`endif
endmodule

// File: doc/key_event_enc.md
Name: key_event_enc

Overview:
Parametrised keypad encoder that generalises the 16-to-4 latch encoder.
- Synchronises and debounces an N-key switch vector, then priority-encodes it.
- Holds the last pressed code, like the current encoder.
- Queues press events in a small ready/valid FIFO, so the radar control logic can consume keys without polling.

Parameters:
N_KEYS, 16, number of switch inputs (>=2)
CODE_W, $clog2(N_KEYS), key code width (derived; do not override)
DEBOUNCE_CYC, 1000, stable cycles required before a vector change is accepted (>=1)
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  reset, synchronous, active-low
psw  in  N_KEYS  raw asynchronous key switches, 1 = pressed
out  out  CODE_W  code of last debounced press, held
pushed  out  1  level: debounced vector non-zero
multi  out  1  level: more than one debounced key pressed
ev_valid  out  1  FIFO non-empty
ev_code  out  CODE_W  code at FIFO head
ev_ready  in  1  consumer pop; pop occurs when ev_valid & ev_ready
overflow  out  1  sticky: a press event was dropped
clr_ovf  in  1  clears overflow

Behaviour:
- Reset (nrst low at an edge) clears:
  - sync stages, candidate, counter, debounced vector and FIFO pointers/count
  - outputs: out=0, pushed=0, multi=0, ev_valid=0, overflow=0
  - Reset mid-debounce or with a non-empty FIFO discards everything.
- Synchroniser: two-flop stage per bit, giving s2.
- Debounce (one shared counter over the whole vector), each edge:
  - if s2 != cand: cand<=s2, cnt<=0
  - else if cnt==DEBOUNCE_CYC-1: deb<=cand; cnt holds
  - else cnt<=cnt+1
  - An isolated psw change is committed to deb at edge DEBOUNCE_CYC+3 after first sampling.
  - Any bounce restarts the count.
- Encode: lowest-index set bit of deb wins. pushed = |deb. multi = popcount(deb) > 1. pushed and multi are registered from deb and update on the same edge as deb.
- Press event: on the edge where deb goes from all-zero to non-zero:
  - out <= code(new deb)
  - FIFO write of the same code
- No press event for:
  - additional keys pressed while another is already held
  - changes between non-zero vectors
  - releases (see optional feature)
- FIFO:
  - ev_valid = count != 0; ev_code = head entry (registered storage, no bypass).
  - Write at edge E is visible on ev_valid after E.
  - Full + write + no pop: event dropped, overflow<=1, contents unchanged.
  - Full + write + pop on the same edge: both happen, count stays FULL, no overflow.
  - Empty + pop request: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: set has priority over clr_ovf in the same cycle.

Optional Feature:
KEY_RELEASE_EV_EN
- Defined:
  - Event entries are CODE_W+1 bits wide, and an extra output port ev_rel (1 bit) gives the head entry's flag.
  - When deb goes from non-zero to all-zero, the code of the previous deb is queued with ev_rel=1.
  - Press entries carry ev_rel=0.
  - Same overflow rules apply.
- Undefined: no ev_rel port; releases generate no entry.

Decomposition:
- Package key_pkg holds:
  - function prio_enc(vector) -> code
  - function popcount
  - the event-entry typedef (a struct with a code field and, under the macro, a rel field)
- Sub-module key_debounce (synchroniser + counter + deb register, parametrised on N_KEYS and DEBOUNCE_CYC).
- FIFO and event logic live inline in key_event_enc.

Test Plan (DEBOUNCE_CYC=4, FIFO_DEPTH=4, N_KEYS=16):
- Clean press: psw=16'h0020 held.
  - pushed=1, out=5, ev_valid=1, ev_code=5 after edge 7.
  - ev_ready=1 for one cycle -> ev_valid=0.
- Bounce: psw toggles 0x0020/0x0000 every 2 cycles for 20 cycles, then stays at 0x0020.
  - No event during toggling.
  - A single event of code 5 arrives 7 edges after the final stable change.
- Multi-key: psw=0x0090.
  - out=4, multi=1, one event.
  - Then psw=0x0080: no new event, multi=0.
- Overflow: five distinct press/release cycles with ev_ready=0.
  - Four entries are queued and the fifth is dropped; overflow=1.
  - Drain returns the codes in order.
  - clr_ovf clears overflow.
- Full with simultaneous push/pop: FIFO full, ev_ready=1 on the press-commit edge.
  - count remains 4, overflow stays 0, new code appears at the tail.
- Reset mid-operation: nrst=0 one edge while FIFO holds 2 entries and the debounce count is in progress.
  - All outputs are 0 next cycle.
  - Held psw re-debounces and produces a fresh event.
